// File: rtl/prefetch_buffer_pkg.sv
// Shared definitions for the data-side prefetch buffer: default sizing and
// FSM state encodings used by the top level.
package prefetch_buffer_pkg;

    localparam int PFB_ENT_NUM_DEF = 4;
    localparam int PFB_LINE_W_DEF  = 128;
    localparam int PFB_PF_EN_DEF   = 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MISS = 3'd1;
    localparam logic [2:0] ST_FILL = 3'd2;
    localparam logic [2:0] ST_UNC  = 3'd3;
    localparam logic [2:0] ST_HIT  = 3'd4;

    // Number of byte-offset bits inside one cache line.
    function automatic int pfb_off_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/pfb_entry_array.sv
// Prefetch entry storage: line tags, line data and valid/pending/discard
// bits, plus the lookup, snoop and allocation match vectors. At most one
// entry is pending at a time because only one refill is ever outstanding.
module pfb_entry_array
    import prefetch_buffer_pkg::*;
#(
    parameter int ENT_NUM = PFB_ENT_NUM_DEF,
    parameter int LINE_W  = PFB_LINE_W_DEF,
    parameter int TAG_W   = 32 - pfb_off_bits(PFB_LINE_W_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              hit,
    output logic [LINE_W-1:0] hit_data,
    input  logic              consume,
    input  logic              snoop,
    input  logic [TAG_W-1:0]  snoop_tag,
    input  logic              alloc,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic              fill,
    input  logic [LINE_W-1:0] fill_data
);

    localparam int IDX_W = $clog2(ENT_NUM);

    logic [TAG_W-1:0]   tags [ENT_NUM];
    logic [LINE_W-1:0]  data [ENT_NUM];
    logic [ENT_NUM-1:0] valid;
    logic [ENT_NUM-1:0] pending;
    logic [ENT_NUM-1:0] discard;
    logic [IDX_W-1:0]   rr_ptr;

    logic [ENT_NUM-1:0] rd_match;
    logic [ENT_NUM-1:0] snoop_match;
    logic [ENT_NUM-1:0] alloc_match;
    logic [IDX_W-1:0]   hit_idx;
    logic [IDX_W-1:0]   reuse_idx;
    logic [IDX_W-1:0]   alloc_idx;
    logic               reuse;

    // Per-entry tag comparisons; snoop and reuse also look at pending entries.
    always_comb begin
        for (int i = 0; i < ENT_NUM; i++) begin
            rd_match[i]    = valid[i] && (tags[i] == rd_tag);
            snoop_match[i] = (valid[i] || pending[i]) && (tags[i] == snoop_tag);
            alloc_match[i] = (valid[i] || pending[i]) && (tags[i] == alloc_tag);
        end
    end

    // Encode match vectors to indices and choose the allocation slot.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        reuse     = 1'b0;
        reuse_idx = '0;
        for (int i = ENT_NUM - 1; i >= 0; i--) begin
            if (rd_match[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (alloc_match[i]) begin
                reuse     = 1'b1;
                reuse_idx = IDX_W'(i);
            end
        end
        alloc_idx = reuse ? reuse_idx : rr_ptr;
        hit_data  = data[hit_idx];
    end

    // Entry state updates: snoop invalidation, hit consumption, refill
    // completion and allocation of the next-line prefetch slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= '0;
            pending <= '0;
            discard <= '0;
            rr_ptr  <= '0;
        end else begin
            for (int i = 0; i < ENT_NUM; i++) begin
                if (snoop && snoop_match[i]) begin
                    valid[i] <= 1'b0;
                    if (pending[i]) begin
                        discard[i] <= 1'b1;
                    end
                end
            end
            if (consume) begin
                valid[hit_idx] <= 1'b0;
            end
            if (fill) begin
                for (int i = 0; i < ENT_NUM; i++) begin
                    if (pending[i]) begin
                        pending[i] <= 1'b0;
                        discard[i] <= 1'b0;
                        if (!discard[i] && !(snoop && snoop_match[i])) begin
                            valid[i] <= 1'b1;
                            data[i]  <= fill_data;
                        end
                    end
                end
            end
            if (alloc) begin
                tags[alloc_idx]    <= alloc_tag;
                valid[alloc_idx]   <= 1'b0;
                pending[alloc_idx] <= 1'b1;
                discard[alloc_idx] <= snoop && (snoop_tag == alloc_tag);
                if (!reuse) begin
                    rr_ptr <= rr_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prefetch_buffer.sv
// Next-line prefetch buffer between the dcache and the AXI bridge. A cached
// miss fetches two lines; the lower goes to the cache, the upper is parked
// in an entry so a following sequential read is served without AXI traffic.
module prefetch_buffer
    import prefetch_buffer_pkg::*;
#(
    parameter int ENT_NUM = PFB_ENT_NUM_DEF,
    parameter int LINE_W  = PFB_LINE_W_DEF,
    parameter int PF_EN   = PFB_PF_EN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cache_rd_req,
    input  logic                cache_rd_type,
    input  logic [31:0]         cache_rd_addr,
    output logic                cache_rd_rdy,
    output logic                cache_ret_valid,
    output logic [LINE_W-1:0]   cache_ret_data,
    input  logic                cache_wr_req,
    input  logic [31:0]         cache_wr_addr,
    output logic                axi_rd_req,
    output logic                axi_rd_type,
    output logic [31:0]         axi_rd_addr,
    input  logic                axi_rd_rdy,
    input  logic                axi_ret_valid,
    input  logic [2*LINE_W-1:0] axi_ret_data,
    input  logic                axi_ret_half
);

    localparam int OFF   = pfb_off_bits(LINE_W);
    localparam int TAG_W = 32 - OFF;
    localparam bit PF_ON = (PF_EN != 0);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [LINE_W-1:0] hit_data_q;

    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  snoop_tag;
    logic [TAG_W-1:0]  alloc_tag;
    logic              arr_hit;
    logic [LINE_W-1:0] arr_hit_data;
    logic              hit_ok;
    logic              idle_live;
    logic              take_hit;
    logic              handshake;
    logic              alloc;
    logic              fill;
    logic              unused_addr_bits;

    assign rd_tag           = cache_rd_addr[31:OFF];
    assign snoop_tag        = cache_wr_addr[31:OFF];
    assign alloc_tag        = rd_tag + 1'b1;
    assign unused_addr_bits = ^{cache_rd_addr[OFF-1:0], cache_wr_addr[OFF-1:0]};

    // Request-side decode: a same-line snoop turns a would-be hit into a miss.
    always_comb begin
        hit_ok       = PF_ON && cache_rd_type && arr_hit &&
                       !(cache_wr_req && (snoop_tag == rd_tag));
        idle_live    = (state == ST_IDLE) && !reset;
        take_hit     = idle_live && cache_rd_req && hit_ok;
        axi_rd_req   = idle_live && cache_rd_req && !hit_ok;
        axi_rd_type  = cache_rd_type;
        axi_rd_addr  = cache_rd_addr;
        cache_rd_rdy = idle_live && (hit_ok || axi_rd_rdy);
        handshake    = axi_rd_req && axi_rd_rdy;
        alloc        = PF_ON && handshake && cache_rd_type;
        fill         = (state == ST_FILL) && axi_ret_valid && !reset;
    end

    // Return path to the cache, selected by the current state.
    always_comb begin
        cache_ret_valid = 1'b0;
        cache_ret_data  = axi_ret_data[LINE_W-1:0];
        if (!reset) begin
            case (state)
                ST_MISS: cache_ret_valid = axi_ret_half;
                ST_UNC:  cache_ret_valid = axi_ret_valid;
                ST_HIT: begin
                    cache_ret_valid = 1'b1;
                    cache_ret_data  = hit_data_q;
                end
                default: cache_ret_valid = 1'b0;
            endcase
        end
    end

    // Next-state logic; returns arriving in IDLE or HIT are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (take_hit) begin
                    state_nxt = ST_HIT;
                end else if (handshake) begin
                    state_nxt = cache_rd_type ? ST_MISS : ST_UNC;
                end
            end
            ST_MISS: if (axi_ret_half)  state_nxt = ST_FILL;
            ST_FILL: if (axi_ret_valid) state_nxt = ST_IDLE;
            ST_UNC:  if (axi_ret_valid) state_nxt = ST_IDLE;
            ST_HIT:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and capture of the buffered line on a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
            if (take_hit) begin
                hit_data_q <= arr_hit_data;
            end
        end
    end

    pfb_entry_array #(
        .ENT_NUM (ENT_NUM),
        .LINE_W  (LINE_W),
        .TAG_W   (TAG_W)
    ) u_entries (
        .clk       (clk),
        .reset     (reset),
        .rd_tag    (rd_tag),
        .hit       (arr_hit),
        .hit_data  (arr_hit_data),
        .consume   (take_hit),
        .snoop     (cache_wr_req),
        .snoop_tag (snoop_tag),
        .alloc     (alloc),
        .alloc_tag (alloc_tag),
        .fill      (fill),
        .fill_data (axi_ret_data[2*LINE_W-1:LINE_W])
    );

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench for prefetch_buffer: expected cache return lines are
// queued when a read is issued and compared whenever the DUT returns data.
module tb_prefetch_buffer;

    localparam int LINE_W  = 128;
    localparam int ENT_NUM = 4;
    localparam int LB      = LINE_W / 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                cache_rd_req;
    logic                cache_rd_type;
    logic [31:0]         cache_rd_addr;
    logic                cache_rd_rdy;
    logic                cache_ret_valid;
    logic [LINE_W-1:0]   cache_ret_data;
    logic                cache_wr_req;
    logic [31:0]         cache_wr_addr;
    logic                axi_rd_req;
    logic                axi_rd_type;
    logic [31:0]         axi_rd_addr;
    logic                axi_rd_rdy;
    logic                axi_ret_valid;
    logic [2*LINE_W-1:0] axi_ret_data;
    logic                axi_ret_half;

    logic [LINE_W-1:0] sb [$];
    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    prefetch_buffer #(
        .ENT_NUM (ENT_NUM),
        .LINE_W  (LINE_W),
        .PF_EN   (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cache_rd_req    (cache_rd_req),
        .cache_rd_type   (cache_rd_type),
        .cache_rd_addr   (cache_rd_addr),
        .cache_rd_rdy    (cache_rd_rdy),
        .cache_ret_valid (cache_ret_valid),
        .cache_ret_data  (cache_ret_data),
        .cache_wr_req    (cache_wr_req),
        .cache_wr_addr   (cache_wr_addr),
        .axi_rd_req      (axi_rd_req),
        .axi_rd_type     (axi_rd_type),
        .axi_rd_addr     (axi_rd_addr),
        .axi_rd_rdy      (axi_rd_rdy),
        .axi_ret_valid   (axi_ret_valid),
        .axi_ret_data    (axi_ret_data),
        .axi_ret_half    (axi_ret_half)
    );

    // Memory contents model: a distinct pattern per line address.
    function automatic logic [LINE_W-1:0] line_pat(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:4], 4'h0};
        return {a ^ 32'hA5A5_5A5A, ~a, a + 32'h0BAD_0000, a};
    endfunction

    // Scoreboard: every returned line must match the oldest queued expectation.
    always @(negedge clk) begin
        if (cache_ret_valid === 1'b1) begin
            checks_total++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL ret_unexpected: got return data %h, required no return", cache_ret_data);
            end else begin
                logic [LINE_W-1:0] exp;
                exp = sb.pop_front();
                if (cache_ret_data !== exp)
                    $display("[TB] FAIL ret_data: got %h, required %h", cache_ret_data, exp);
                else
                    checks_passed++;
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
    endtask

    // Issue one read and play the AXI bridge for it. Observations only; the
    // calling test decides what they should have been.
    task automatic do_read(input logic [31:0] addr, input logic cached,
                           input logic snoop_now, input logic [31:0] snoop_addr,
                           input logic fill_snoop, input logic [31:0] fill_snoop_addr,
                           input logic reset_in_fill,
                           output logic went_axi, output logic [31:0] seen_addr,
                           output logic seen_type, output logic rdy_seen);
        cache_rd_req  = 1'b1;
        cache_rd_type = cached;
        cache_rd_addr = addr;
        cache_wr_req  = snoop_now;
        cache_wr_addr = snoop_addr;
        sb.push_back(line_pat(addr));
        @(negedge clk);
        went_axi  = axi_rd_req;
        seen_addr = axi_rd_addr;
        seen_type = axi_rd_type;
        rdy_seen  = cache_rd_rdy;
        @(posedge clk);
        #1 cache_rd_req = 1'b0;
        cache_wr_req = 1'b0;
        if (went_axi === 1'b1) begin
            @(posedge clk);
            #1;
            if (cached) begin
                axi_ret_half = 1'b1;
                axi_ret_data = {line_pat(addr + LB), line_pat(addr)};
                @(posedge clk);
                #1 axi_ret_half = 1'b0;
                if (fill_snoop) begin
                    cache_wr_req  = 1'b1;
                    cache_wr_addr = fill_snoop_addr;
                end
                if (reset_in_fill) reset = 1'b1;
                @(posedge clk);
                #1 cache_wr_req = 1'b0;
                reset = 1'b0;
                axi_ret_valid = 1'b1;
                @(posedge clk);
                #1 axi_ret_valid = 1'b0;
            end else begin
                axi_ret_half = 1'b1;
                axi_ret_data = {2*LINE_W{1'b1}};
                @(posedge clk);
                #1 axi_ret_half = 1'b0;
                axi_ret_data  = {~line_pat(addr), line_pat(addr)};
                axi_ret_valid = 1'b1;
                @(posedge clk);
                #1 axi_ret_valid = 1'b0;
            end
            axi_ret_data = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        reset         = 1'b1;
        cache_rd_req  = 1'b1;
        cache_rd_type = 1'b1;
        cache_rd_addr = 32'h0000_0040;
        axi_rd_rdy    = 1'b0;
        @(negedge clk);
        checks_total++;
        if (axi_rd_req !== 1'b0) $display("[TB] FAIL reset_axi_req: got %b, required 0", axi_rd_req);
        else checks_passed++;
        checks_total++;
        if (cache_ret_valid !== 1'b0) $display("[TB] FAIL reset_ret_valid: got %b, required 0", cache_ret_valid);
        else checks_passed++;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        a = axi_rd_addr;
        checks_total++;
        if (axi_rd_req !== 1'b1 || a !== 32'h0000_0040)
            $display("[TB] FAIL post_reset_fwd: got req=%b addr=%h, required req=1 addr=00000040", axi_rd_req, a);
        else checks_passed++;
        checks_total++;
        if (cache_rd_rdy !== 1'b0) $display("[TB] FAIL rdy_follows_bridge: got %b, required 0", cache_rd_rdy);
        else checks_passed++;
        @(posedge clk);
        #1 cache_rd_req = 1'b0;
        axi_rd_rdy = 1'b1;
    endtask

    task automatic test_cached_prefetch();
        logic w, t, r;
        logic [31:0] a;
        do_read(32'h0000_1000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b1 || a !== 32'h0000_1000 || t !== 1'b1)
            $display("[TB] FAIL miss_1000: got req=%b addr=%h type=%b, required 1/00001000/1", w, a, t);
        else checks_passed++;
        do_read(32'h0000_1010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b0 || r !== 1'b1)
            $display("[TB] FAIL hit_1010: got axi_req=%b rdy=%b, required 0/1", w, r);
        else checks_passed++;
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL prefetch_drain: got %0d pending returns, required 0", sb.size());
        else checks_passed++;
    endtask

    task automatic test_uncached();
        logic w, t, r;
        logic [31:0] a;
        do_read(32'hBFD0_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b1 || a !== 32'hBFD0_0000 || t !== 1'b0)
            $display("[TB] FAIL uncached_fwd: got req=%b addr=%h type=%b, required 1/bfd00000/0", w, a, t);
        else checks_passed++;
        do_read(32'hBFD0_0010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b1) $display("[TB] FAIL uncached_no_alloc: got axi_req=%b, required 1", w);
        else checks_passed++;
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL uncached_drain: got %0d pending returns, required 0", sb.size());
        else checks_passed++;
    endtask

    task automatic test_snoop_valid();
        logic w, t, r;
        logic [31:0] a;
        do_read(32'h0000_2000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        cache_wr_req  = 1'b1;
        cache_wr_addr = 32'h0000_2014;
        @(posedge clk);
        #1 cache_wr_req = 1'b0;
        do_read(32'h0000_2010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b1 || a !== 32'h0000_2010)
            $display("[TB] FAIL snoop_inval: got req=%b addr=%h, required 1/00002010", w, a);
        else checks_passed++;
        do_read(32'h0000_2020, 1'b1, 1'b1, 32'h0000_2028, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b1) $display("[TB] FAIL snoop_beats_hit: got axi_req=%b, required 1", w);
        else checks_passed++;
    endtask

    task automatic test_snoop_pending();
        logic w, t, r;
        logic [31:0] a;
        do_read(32'h0000_3000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3010, 1'b0, w, a, t, r);
        do_read(32'h0000_3010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b1) $display("[TB] FAIL fill_discard: got axi_req=%b, required 1", w);
        else checks_passed++;
    endtask

    task automatic test_eviction();
        logic w, t, r;
        logic [31:0] a;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_read(32'(i) << 8, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
            checks_total++;
            if (w !== 1'b1) $display("[TB] FAIL evict_fill_%0d: got axi_req=%b, required 1", i, w);
            else checks_passed++;
        end
        for (int i = 1; i < 5; i++) begin
            do_read((32'(i) << 8) + 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
            checks_total++;
            if (w !== 1'b0) $display("[TB] FAIL evict_hit_%0d: got axi_req=%b, required 0", i, w);
            else checks_passed++;
        end
        do_read(32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b1) $display("[TB] FAIL evict_victim: got axi_req=%b, required 1", w);
        else checks_passed++;
    endtask

    task automatic test_wrap_reset();
        logic w, t, r;
        logic [31:0] a;
        apply_reset();
        do_read(32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        do_read(32'h0000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b0) $display("[TB] FAIL wrap_hit: got axi_req=%b, required 0", w);
        else checks_passed++;
        do_read(32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, w, a, t, r);
        do_read(32'h0000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        checks_total++;
        if (w !== 1'b1) $display("[TB] FAIL reset_abandons_fill: got axi_req=%b, required 1", w);
        else checks_passed++;
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL wrap_drain: got %0d pending returns, required 0", sb.size());
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        logic w, t, r;
        logic [31:0] a;
        do_read(32'h0000_5000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, w, a, t, r);
        cache_rd_req  = 1'b1;
        cache_rd_type = 1'b1;
        cache_rd_addr = 32'h0000_5010;
        sb.push_back(line_pat(32'h0000_5010));
        @(negedge clk);
        checks_total++;
        if (cache_rd_rdy !== 1'b1 || axi_rd_req !== 1'b0)
            $display("[TB] FAIL b2b_accept: got rdy=%b axi_req=%b, required 1/0", cache_rd_rdy, axi_rd_req);
        else checks_passed++;
        @(negedge clk);
        checks_total++;
        if (cache_rd_rdy !== 1'b0 || axi_rd_req !== 1'b0)
            $display("[TB] FAIL b2b_busy: got rdy=%b axi_req=%b, required 0/0", cache_rd_rdy, axi_rd_req);
        else checks_passed++;
        @(posedge clk);
        #1 cache_rd_req = 1'b0;
        axi_ret_half  = 1'b1;
        axi_ret_valid = 1'b1;
        @(negedge clk);
        checks_total++;
        if (cache_ret_valid !== 1'b0) $display("[TB] FAIL idle_ret_ignored: got %b, required 0", cache_ret_valid);
        else checks_passed++;
        @(posedge clk);
        #1 axi_ret_half = 1'b0;
        axi_ret_valid = 1'b0;
        @(posedge clk);
        #1;
        checks_total++;
        if (sb.size() != 0) $display("[TB] FAIL b2b_drain: got %0d pending returns, required 0", sb.size());
        else checks_passed++;
    endtask

    initial begin
        reset         = 1'b1;
        cache_rd_req  = 1'b0;
        cache_rd_type = 1'b0;
        cache_rd_addr = '0;
        cache_wr_req  = 1'b0;
        cache_wr_addr = '0;
        axi_rd_rdy    = 1'b1;
        axi_ret_valid = 1'b0;
        axi_ret_half  = 1'b0;
        axi_ret_data  = '0;
        test_reset();
        apply_reset();
        test_cached_prefetch();
        test_uncached();
        test_snoop_valid();
        test_snoop_pending();
        test_eviction();
        test_wrap_reset();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
